// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Round-robin scheduler sharing one sequential FP multiplier between N
//   requesters. The winner's operands are captured on the grant edge and held
//   on fp_a/fp_b until the next grant. A watchdog aborts an operation whose
//   done never arrives and returns a quiet NaN with res_err set.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req        per-requester request level [N]
//   a_bus      operand A, requester i in bits [32i+31:32i]
//   b_bus      operand B, same packing
//   gnt        one-hot grant, high during the ISSUE cycle
//   fp_start   one-cycle start pulse to the multiplier
//   fp_a/fp_b  registered operands to the multiplier
//   fp_done    multiplier completion, honoured only in WAIT
//   fp_result  multiplier product, valid with fp_done
//   res_valid  one-cycle result strobe (RESP state)
//   res_id     requester owning the result
//   res_data   product, or 32'h7FC00000 on timeout
//   res_err    timeout flag, qualified by res_valid
//   busy       high whenever the scheduler is not IDLE
module fp_mul_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = $clog2(N),
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*32-1:0]   a_bus,
  input  logic [N*32-1:0]   b_bus,
  output logic [N-1:0]      gnt,
  output logic              fp_start,
  output logic [31:0]       fp_a,
  output logic [31:0]       fp_b,
  input  logic              fp_done,
  input  logic [31:0]       fp_result,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [31:0]       res_data,
  output logic              res_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int             TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT - 1);
  localparam int             SW      = IDW + 1;
  localparam logic [31:0]    QNAN    = 32'h7FC0_0000;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [31:0]      fp_a_q, fp_a_d;
  logic [31:0]      fp_b_q, fp_b_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_err_q, res_err_d;

  // Unpack the operand buses into per-requester words.
  logic [31:0] a_arr [N];
  logic [31:0] b_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = a_bus[32*gi +: 32];
      assign b_arr[gi] = b_bus[32*gi +: 32];
    end
  endgenerate

  // Round-robin pick: scan last+1, last+2, ... wrapping modulo N. The sum is
  // one bit wider than the id so last+N never overflows before the wrap.
  logic [IDW-1:0] win;
  logic           any_req;
  logic [SW-1:0]  cand;

  always_comb begin
    win     = last_q;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + SW'(k);
      if (cand >= SW'(N)) cand = cand - SW'(N);
      if (!any_req && req[cand[IDW-1:0]]) begin
        any_req = 1'b1;
        win     = cand[IDW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; fp_done has priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (fp_done || (timer_q == TMAX)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    gnt       = '0;
    fp_start  = 1'b0;
    res_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        gnt[res_id_q] = 1'b1;
        fp_start      = 1'b1;
      end
      RESP:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state. Operands only move on the IDLE grant edge, and the
  // multiplier result is only looked at in WAIT, so stray done pulses and
  // operand bus activity elsewhere are harmless.
  always_comb begin
    last_d     = last_q;
    timer_d    = timer_q;
    fp_a_d     = fp_a_q;
    fp_b_d     = fp_b_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          fp_a_d   = a_arr[win];
          fp_b_d   = b_arr[win];
          res_id_d = win;
          last_d   = win;
        end
      end
      ISSUE: timer_d = '0;
      WAIT: begin
        if (fp_done) begin
          res_data_d = fp_result;
          res_err_d  = 1'b0;
        end else if (timer_q == TMAX) begin
          res_data_d = QNAN;
          res_err_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the pointer resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= IDW'(N - 1);
      timer_q    <= '0;
      fp_a_q     <= '0;
      fp_b_q     <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      timer_q    <= timer_d;
      fp_a_q     <= fp_a_d;
      fp_b_q     <= fp_b_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign fp_a     = fp_a_q;
  assign fp_b     = fp_b_q;
  assign res_id   = res_id_q;
  assign res_data = res_data_q;
  assign res_err  = res_err_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter
//   Directed bench for fp_mul_arbiter (N=4, TIMEOUT=64). Inputs are driven and
//   outputs sampled on the falling clock edge; the bench plays the multiplier.
module tb_fp_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] a_bus;
  logic [127:0] b_bus;
  logic [3:0]   gnt;
  logic         fp_start;
  logic [31:0]  fp_a;
  logic [31:0]  fp_b;
  logic         fp_done;
  logic [31:0]  fp_result;
  logic         res_valid;
  logic [1:0]   res_id;
  logic [31:0]  res_data;
  logic         res_err;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] base_a [4];
  logic [31:0] base_b [4];

  always #5 clk = ~clk;

  fp_mul_arbiter #(.N(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .fp_start  (fp_start),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_done   (fp_done),
    .fp_result (fp_result),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_bus();
    for (int i = 0; i < 4; i++) begin
      a_bus[32*i +: 32] = base_a[i];
      b_bus[32*i +: 32] = base_b[i];
    end
  endtask

  // Returns at the falling edge inside the ISSUE cycle.
  task automatic wait_gnt(input int exp_id, output int cyc);
    int id;
    cyc = -1;
    id  = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        cyc = k;
        break;
      end
    end
    check("gnt_seen", (cyc > 0) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) if (gnt[i]) id = i;
    check("gnt_id", id, exp_id);
    check("gnt_onehot", $countones(gnt), 1);
    check("fp_start", fp_start, 1);
    check("fp_a_grant", fp_a, base_a[exp_id]);
    check("fp_b_grant", fp_b, base_b[exp_id]);
    $display("grant id=%0d after %0d cycles fp_a=%h fp_b=%h", id, cyc, fp_a, fp_b);
  endtask

  // Plays the multiplier from the ISSUE cycle: done is driven during WAIT
  // cycle done_at (0 = never). Operand buses are scrambled every cycle.
  // Returns at the falling edge inside the RESP cycle.
  task automatic serve(input int done_at, input logic [31:0] r, input int exp_id,
                       input logic exp_err, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = k;
        break;
      end
      check("fp_a_hold", fp_a, base_a[exp_id]);
      check("fp_b_hold", fp_b, base_b[exp_id]);
      check("fp_start_wait", fp_start, 0);
      fp_done   = (k == done_at);
      fp_result = (k == done_at) ? r : 32'hDEAD_BEEF;
      a_bus     = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_bus     = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    fp_done = 1'b0;
    load_bus();
    check("res_latency", lat, exp_lat);
    check("res_id", res_id, exp_id);
    check("res_data", res_data, exp_data);
    check("res_err", res_err, exp_err);
    check("fp_a_resp", fp_a, base_a[exp_id]);
    $display("result id=%0d data=%h err=%0d latency=%0d", res_id, res_data, res_err, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_fp_start"}, fp_start, 0);
    check({tag, "_fp_a"}, fp_a, 0);
    check({tag, "_fp_b"}, fp_b, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_id"}, res_id, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int cyc;
  int seq_id  [8] = '{0, 1, 2, 3, 0, 3, 0, 3};
  logic [3:0] seq_req [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111,
                              4'b1111, 4'b1000, 4'b1001, 4'b1001};

  initial begin
    rst       = 1'b0;
    req       = 4'b0000;
    fp_done   = 1'b0;
    fp_result = 32'h0;
    for (int i = 0; i < 4; i++) begin
      base_a[i] = 32'h3F80_0000 + 32'(i) * 32'h0010_0000;
      base_b[i] = 32'h4100_0000 + 32'(i) * 32'h0001_0000;
    end
    load_bus();

    // Reset values
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Single operation: 2.0 * 3.0 = 6.0, done 30 cycles after start
    @(negedge clk);
    base_a[0] = 32'h4000_0000;
    base_b[0] = 32'h4040_0000;
    load_bus();
    req = 4'b0001;
    wait_gnt(0, cyc);
    check("single_gnt", gnt, 4'b0001);
    check("single_gnt_latency", cyc, 1);
    req = 4'b0000;
    serve(30, 32'h40C0_0000, 0, 1'b0, 32'h40C0_0000, 31);
    @(negedge clk);
    check("single_busy_after", busy, 0);
    check("single_valid_after", res_valid, 0);

    // Fairness from a fresh pointer
    for (int i = 0; i < 4; i++) base_a[i] = 32'h3F80_0000 + 32'(i) * 32'h0010_0000;
    load_bus();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = seq_req[i];
      wait_gnt(seq_id[i], cyc);
      if (i > 0) check("b2b_gnt_gap", cyc, 2);
      serve(1, 32'h4200_0000 + 32'(i), seq_id[i], 1'b0, 32'h4200_0000 + 32'(i), 2);
    end

    // Timeout on requester 0 while 2 waits, then done on the last WAIT cycle
    req = 4'b0101;
    wait_gnt(0, cyc);
    req = 4'b0100;
    serve(0, 32'h0, 0, 1'b1, 32'h7FC0_0000, 65);
    wait_gnt(2, cyc);
    req = 4'b0000;
    serve(64, 32'h3F80_0000, 2, 1'b0, 32'h3F80_0000, 65);

    // Spurious done through RESP->IDLE and while idle
    fp_done   = 1'b1;
    fp_result = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("spurious_valid", res_valid, 0);
      check("spurious_busy", busy, 0);
      check("spurious_data", res_data, 32'h3F80_0000);
    end
    fp_done = 1'b0;

    // Reset in the middle of WAIT
    req = 4'b0001;
    wait_gnt(0, cyc);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    check("post_reset_valid", res_valid, 0);
    req = 4'b0011;
    wait_gnt(0, cyc);
    req = 4'b0010;
    serve(5, 32'h4080_0000, 0, 1'b0, 32'h4080_0000, 6);
    wait_gnt(1, cyc);
    req = 4'b0000;
    serve(3, 32'h4110_0000, 1, 1'b0, 32'h4110_0000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Round-robin scheduler that shares one sequential FP multiplier between N requesters.
- Drives the multiplier's start/done handshake and captures the winner's operands.
- Holds those operands stable for the whole operation, then returns the 32-bit result tagged with the requester id.
- Includes a watchdog that aborts an operation whose done never arrives.

Parameters:
- N, 4, number of requesters (>= 2).
- IDW, $clog2(N), width of the requester id.
- TIMEOUT, 64, maximum WAIT cycles before an operation is aborted (>= 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level.
- a_bus  in  N*32  operand A per requester; slice i = bits [32i+31:32i].
- b_bus  in  N*32  operand B per requester, same packing.
- gnt  out  N  one-hot grant pulse; operands of the granted requester are captured.
- fp_start  out  1  single-cycle start pulse to the multiplier.
- fp_a  out  32  registered operand A to the multiplier.
- fp_b  out  32  registered operand B to the multiplier.
- fp_done  in  1  completion from the multiplier.
- fp_result  in  32  multiplier result, valid while fp_done=1.
- res_valid  out  1  single-cycle result strobe.
- res_id  out  IDW  requester the result belongs to.
- res_data  out  32  product; 32'h7FC00000 on timeout.
- res_err  out  1  timeout flag, qualified by res_valid.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; gnt=0, fp_start=0, fp_a=0, fp_b=0, res_valid=0, res_id=0, res_data=0, res_err=0, busy=0.
  - Round-robin pointer last=N-1, so requester 0 has highest priority first. Timer=0.
  - Reset in any state discards the in-flight operation; no res_valid is produced for it.
- States IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered or Moore.
- IDLE:
  - If any req bit is 1, the winner is the first set bit scanning last+1, last+2, ... modulo N.
  - On that edge: fp_a/fp_b <= the winner's slices, res_id <= winner, last <= winner, state <= ISSUE.
  - No req: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[res_id]=1 and fp_start=1 in this cycle.
  - Timer cleared; next state WAIT.
- WAIT:
  - fp_done=1: res_data <= fp_result, res_err <= 0, state <= RESP.
  - Else, timer==TIMEOUT-1: res_data <= 32'h7FC00000, res_err <= 1, state <= RESP.
  - Else timer++.
  - fp_done takes priority over timeout in the same cycle.
  - WAIT lasts at most TIMEOUT cycles.
- RESP (exactly 1 cycle):
  - res_valid=1; res_id, res_data and res_err are stable.
  - Next state IDLE. res_data/res_err/res_id hold until overwritten.
- fp_done is ignored outside WAIT: stale or spurious done pulses have no effect.
- fp_a/fp_b change only on an IDLE grant edge, so they are stable from ISSUE through RESP regardless of a_bus/b_bus.
- Requester rules:
  - Hold req and operands until gnt is seen; drop req on the edge after gnt unless a new operation is wanted.
  - A req left high is re-arbitrated in the next IDLE. Fairness: it is granted again only after the other pending requesters.
- Minimum turnaround: IDLE, ISSUE, 1 WAIT, RESP = 4 cycles per operation; back-to-back grants are possible with no extra idle cycle beyond IDLE.
- No result buffering: requesters must accept res_valid when it is strobed.

Test Plan:
- Single op: after reset, req=0001, a0=0x40000000, b0=0x40400000; model asserts fp_done 30 cycles after fp_start with 0x40C00000 -> one cycle gnt=0001 with fp_start=1; fp_a/fp_b stay at the operands; res_valid one cycle after the done cycle with res_id=0, res_data=0x40C00000, res_err=0; busy low the following cycle.
- Fairness: req=1111 held continuously -> grant order 0,1,2,3,0. Then req=1001 with last=3 -> order 0,3. Exactly one gnt bit per operation.
- Timeout: fp_done never asserted, TIMEOUT=64 -> res_valid exactly 65 cycles after the fp_start cycle with res_err=1 and res_data=0x7FC00000; the next pending request is then granted normally.
- Boundary: fp_done first asserted on the 64th WAIT cycle -> success with res_err=0. fp_done pulses while in IDLE or RESP -> no state change and no res_valid.
- Operand stability: change a_bus/b_bus every cycle after the IDLE grant edge -> fp_a/fp_b unchanged until the next grant.
- Reset mid-WAIT: drop rst for 1 cycle during WAIT -> all outputs zero immediately (async); no res_valid for the aborted op. After release with req=0010, requester 1 is granted and completes normally (pointer back to N-1).
